spi_matrix_ctrl: RTL and testbench

Frame controller between the SPI slave and the 2x2 matrix multiplier core. It collects eight operand bytes from the SPI receive path and assembles them into matrices A and B. It then launches one multiplication and returns the four 16-bit result elements through the SPI transmit path (`tx_data` / `load` / `tx_ready`). It also flags dropped bytes and a stalled multiplier.

---
 rtl/spi_matrix_ctrl.sv | 170 +++++++++++++++++
 tb/tb_spi_matrix_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_matrix_ctrl.sv
// Frame controller: gathers eight SPI operand bytes into two 2x2 matrices, launches one
// multiply and streams the four result words back through the SPI transmit handshake.
module spi_matrix_ctrl #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    input  logic                tx_ready,
    output logic [2*DATA_W-1:0] tx_data,
    output logic                load,
    output logic [4*DATA_W-1:0] mat_a,
    output logic [4*DATA_W-1:0] mat_b,
    output logic                mult_start,
    input  logic                mult_done,
    input  logic [8*DATA_W-1:0] mult_result,
    output logic                busy,
    output logic                frame_done,
    output logic                err_overrun,
    output logic                err_timeout,
    input  logic                err_clr
);
    localparam int RES_W = 2 * DATA_W;
    localparam int TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // Last timer value seen in WAIT; expiring here makes err_timeout land exactly TIMEOUT cycles after mult_start.
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

    typedef enum logic [2:0] {
        ST_COLLECT = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SEND    = 3'd3,
        ST_DRAIN   = 3'd4
    } state_t;

    state_t              state_r;
    logic [2:0]          byte_cnt_r;
    logic [1:0]          word_idx_r;
    logic [TW-1:0]       timer_r;
    logic [RES_W-1:0]    result_r [4];
    logic                timeout_hit_s;
    logic                overrun_s;

    // Strobes shared by the frame sequencer and the sticky error flags.
    always_comb begin
        timeout_hit_s = (state_r == ST_WAIT) && !mult_done && (timer_r == TIMER_LAST);
        overrun_s     = rx_valid && (state_r != ST_COLLECT);
    end

    // Frame sequencer: operand capture, multiply launch, result streaming.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_r    <= ST_COLLECT;
            byte_cnt_r <= 3'd0;
            word_idx_r <= 2'd0;
            timer_r    <= '0;
            tx_data    <= '0;
            load       <= 1'b0;
            mat_a      <= '0;
            mat_b      <= '0;
            mult_start <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                result_r[i] <= '0;
            end
        end else begin
            load       <= 1'b0;
            mult_start <= 1'b0;
            frame_done <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (rx_valid) begin
                        if (byte_cnt_r[2]) begin
                            mat_b[byte_cnt_r[1:0]*DATA_W +: DATA_W] <= DATA_W'(rx_data);
                        end else begin
                            mat_a[byte_cnt_r[1:0]*DATA_W +: DATA_W] <= DATA_W'(rx_data);
                        end
                        if (byte_cnt_r == 3'd7) begin
                            byte_cnt_r <= 3'd0;
                            mult_start <= 1'b1;
                            busy       <= 1'b1;
                            state_r    <= ST_START;
                        end else begin
                            byte_cnt_r <= byte_cnt_r + 3'd1;
                        end
                    end
                end
                ST_START: begin
                    timer_r <= '0;
                    state_r <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mult_done) begin
                        for (int i = 0; i < 4; i++) begin
                            result_r[i] <= mult_result[i*RES_W +: RES_W];
                        end
                        word_idx_r <= 2'd0;
                        // A ready slave takes C00 straight away, saving the SEND cycle.
                        if (tx_ready) begin
                            tx_data <= mult_result[RES_W-1:0];
                            load    <= 1'b1;
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else if (timeout_hit_s) begin
                        timer_r <= '0;
                        busy    <= 1'b0;
                        state_r <= ST_COLLECT;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                ST_SEND: begin
                    if (tx_ready) begin
                        tx_data <= result_r[word_idx_r];
                        load    <= 1'b1;
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // The load cycle itself is skipped so loads stay at least three cycles apart.
                    if (frame_done) begin
                        word_idx_r <= 2'd0;
                        state_r    <= ST_COLLECT;
                    end else if (!load && !tx_ready) begin
                        if (word_idx_r == 2'd3) begin
                            frame_done <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            word_idx_r <= word_idx_r + 2'd1;
                            state_r    <= ST_SEND;
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_COLLECT;
                end
            endcase
        end
    end

    // Sticky error flags; a same-cycle set outranks err_clr.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (overrun_s) begin
                err_overrun <= 1'b1;
            end else if (err_clr) begin
                err_overrun <= 1'b0;
            end else begin
                err_overrun <= err_overrun;
            end
            if (timeout_hit_s) begin
                err_timeout <= 1'b1;
            end else if (err_clr) begin
                err_timeout <= 1'b0;
            end else begin
                err_timeout <= err_timeout;
            end
        end
    end

endmodule

// File: tb/tb_spi_matrix_ctrl.sv
// Directed bench for spi_matrix_ctrl: table of operand frames with hand-computed products,
// plus sequences for overrun, timeout, transmit back-pressure and mid-frame reset.
module tb_spi_matrix_ctrl;
    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b0;
    logic [15:0] tx_data;
    logic        load;
    logic [31:0] mat_a, mat_b;
    logic        mult_start;
    logic        mult_done = 1'b0;
    logic [63:0] mult_result = 64'h0;
    logic        busy, frame_done, err_overrun, err_timeout;
    logic        err_clr = 1'b0;

    spi_matrix_ctrl #(.DATA_W(8), .TIMEOUT(64)) dut (
        .sys_clk(sys_clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .load(load), .mat_a(mat_a), .mat_b(mat_b),
        .mult_start(mult_start), .mult_done(mult_done), .mult_result(mult_result),
        .busy(busy), .frame_done(frame_done), .err_overrun(err_overrun),
        .err_timeout(err_timeout), .err_clr(err_clr)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        int          gap;
        int          delay;
        logic [63:0] c;
    } vec_t;

    vec_t vecs [5];
    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // 2x2 product, each element truncated to 16 bits
    function automatic logic [63:0] mat_mul(input logic [31:0] a, input logic [31:0] b);
        logic [15:0] c00, c01, c10, c11;
        c00 = 16'(a[7:0]) * 16'(b[7:0])   + 16'(a[15:8]) * 16'(b[23:16]);
        c01 = 16'(a[7:0]) * 16'(b[15:8])  + 16'(a[15:8]) * 16'(b[31:24]);
        c10 = 16'(a[23:16]) * 16'(b[7:0]) + 16'(a[31:24]) * 16'(b[23:16]);
        c11 = 16'(a[23:16]) * 16'(b[15:8]) + 16'(a[31:24]) * 16'(b[31:24]);
        return {c11, c10, c01, c00};
    endfunction

    // multiplier stub: one-cycle done pulse mult_delay cycles after mult_start
    int mult_delay = 3;
    bit mult_en = 1'b1;
    int mcnt = 0;
    always @(negedge sys_clk) begin
        if (rst) begin
            mcnt <= 0;
            mult_done <= 1'b0;
        end else if (mult_start && mult_en) begin
            mcnt <= mult_delay;
            mult_done <= 1'b0;
        end else if (mcnt == 1) begin
            mcnt <= 0;
            mult_done <= 1'b1;
            mult_result <= mat_mul(mat_a, mat_b);
        end else begin
            if (mcnt > 0) mcnt <= mcnt - 1;
            mult_done <= 1'b0;
        end
    end

    // SPI slave stub: drops tx_ready for two cycles after each load
    bit ready_hold = 1'b0;
    int rdrop = 0;
    always @(negedge sys_clk) begin
        if (load) begin
            tx_ready <= 1'b0;
            rdrop <= 1;
        end else if (rdrop > 0) begin
            tx_ready <= 1'b0;
            rdrop <= rdrop - 1;
        end else begin
            tx_ready <= !ready_hold;
        end
    end

    // observation only
    logic [15:0] words [$];
    int load_cyc [$];
    int n_load = 0, n_start = 0, n_done = 0;
    int start_cyc = 0, to_cyc = 0, busy_fall_cyc = 0, done_cyc = 0;
    logic prev_to = 1'b0, prev_busy = 1'b0;
    always @(negedge sys_clk) begin
        prev_to <= err_timeout;
        prev_busy <= busy;
        if (load) begin
            words.push_back(tx_data);
            load_cyc.push_back(cyc);
            n_load <= n_load + 1;
        end
        if (mult_start) begin
            n_start <= n_start + 1;
            start_cyc <= cyc;
        end
        if (frame_done) n_done <= n_done + 1;
        if (err_timeout && !prev_to) to_cyc <= cyc;
        if (!busy && prev_busy) busy_fall_cyc <= cyc;
    end
    always @(posedge sys_clk) if (mult_done) done_cyc <= cyc;

    function automatic logic [15:0] word_at(input int i);
        if (i < words.size()) return words[i];
        return 16'hxxxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < load_cyc.size()) return load_cyc[i];
        return -1000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bytes(input logic [63:0] frame, input int count, input int gap);
        for (int i = 0; i < count; i++) begin
            rx_data = frame[8*i +: 8];
            rx_valid = 1'b1;
            @(negedge sys_clk);
            rx_valid = 1'b0;
            if (i < count - 1) repeat (gap) @(negedge sys_clk);
        end
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge sys_clk);
            k++;
        end
        check(name, 64'(n_done >= target), 64'd1);
        @(negedge sys_clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge sys_clk);
        err_clr = 1'b0;
    endtask

    task automatic check_words(input int base, input logic [63:0] c, input string tag);
        for (int w = 0; w < 4; w++)
            check($sformatf("%s_word%0d", tag, w), 64'(word_at(base + w)), 64'(c[16*w +: 16]));
        for (int w = 1; w < 4; w++)
            check($sformatf("%s_gap%0d_ge3", tag, w),
                  64'((cyc_at(base + w) - cyc_at(base + w - 1)) >= 3), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int base, l0, s0, d0;
        base = words.size();
        l0 = n_load;
        s0 = n_start;
        d0 = n_done;
        mult_delay = v.delay;
        send_bytes({v.b, v.a}, 8, v.gap);
        check({tag, "_start_busy"}, 64'({mult_start, busy}), 64'd3);
        wait_done(d0 + 1, 300, {tag, "_frame_done"});
        check({tag, "_mat_a"}, 64'(mat_a), 64'(v.a));
        check({tag, "_mat_b"}, 64'(mat_b), 64'(v.b));
        check({tag, "_starts"}, 64'(n_start - s0), 64'd1);
        check({tag, "_loads"}, 64'(n_load - l0), 64'd4);
        check({tag, "_first_load_lat"}, 64'(cyc_at(base) - done_cyc), 64'd1);
        check({tag, "_idle"}, 64'({busy, err_timeout}), 64'd0);
        check_words(base, v.c, tag);
    endtask

    initial begin
        int base, l0, k, rel;
        vecs[0] = '{a: 32'h04030201, b: 32'h01000001, gap: 0,  delay: 3,
                    c: {16'd4, 16'd3, 16'd2, 16'd1}};
        vecs[1] = '{a: 32'h05040302, b: 32'h09080706, gap: 1,  delay: 3,
                    c: {16'd73, 16'd64, 16'd41, 16'd36}};
        vecs[2] = '{a: 32'h05040302, b: 32'h09080706, gap: 40, delay: 5,
                    c: {16'd73, 16'd64, 16'd41, 16'd36}};
        vecs[3] = '{a: 32'hFF0000FF, b: 32'h030201FF, gap: 0,  delay: 1,
                    c: {16'h02FD, 16'h01FE, 16'h00FF, 16'hFE01}};
        vecs[4] = '{a: 32'h04030201, b: 32'h08070605, gap: 2,  delay: 63,
                    c: {16'd50, 16'd43, 16'd22, 16'd19}};

        repeat (3) @(negedge sys_clk);
        rst = 1'b0;
        check("reset_data", {tx_data, mat_a}, 64'd0);
        check("reset_ctrl", {mat_b, load, mult_start, busy, frame_done, err_overrun, err_timeout}, 64'd0);
        @(negedge sys_clk);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // stray byte while waiting for the multiplier
        mult_delay = 12;
        base = words.size();
        send_bytes({vecs[1].b, vecs[1].a}, 8, 0);
        repeat (2) @(negedge sys_clk);
        rx_data = 8'hAA;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        check("ovr_flag", 64'(err_overrun), 64'd1);
        check("ovr_mat_a", 64'(mat_a), 64'(vecs[1].a));
        check("ovr_mat_b", 64'(mat_b), 64'(vecs[1].b));
        rx_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        err_clr = 1'b0;
        check("ovr_set_beats_clr", 64'(err_overrun), 64'd1);
        wait_done(n_done + 1, 300, "ovr_frame_done");
        check_words(base, vecs[1].c, "ovr");
        pulse_clr();
        check("ovr_cleared", 64'(err_overrun), 64'd0);

        // byte arriving in the frame_done cycle is dropped
        mult_delay = 3;
        send_bytes({vecs[0].b, vecs[0].a}, 8, 0);
        k = 0;
        while (!frame_done && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        check("fd_seen", 64'(frame_done), 64'd1);
        check("fd_busy_low", 64'(busy), 64'd0);
        rx_data = 8'h55;
        rx_valid = 1'b1;
        @(negedge sys_clk);
        rx_valid = 1'b0;
        check("fd_overrun", 64'(err_overrun), 64'd1);
        @(negedge sys_clk);
        pulse_clr();
        run_vec(vecs[1], "after_fd");

        // multiplier never answers
        mult_en = 1'b0;
        l0 = n_load;
        send_bytes({vecs[1].b, vecs[1].a}, 8, 0);
        k = 0;
        while (!err_timeout && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        @(negedge sys_clk);
        check("to_flag", 64'(err_timeout), 64'd1);
        check("to_rise_cycle", 64'(to_cyc - start_cyc), 64'd64);
        check("to_busy_fall", 64'(busy_fall_cyc - start_cyc), 64'd64);
        check("to_no_load", 64'(n_load - l0), 64'd0);
        mult_en = 1'b1;
        pulse_clr();
        check("to_cleared", 64'(err_timeout), 64'd0);
        run_vec(vecs[3], "after_to");

        // transmit back-pressure
        @(posedge sys_clk);
        #1 ready_hold = 1'b1;
        @(negedge sys_clk);
        base = words.size();
        l0 = n_load;
        mult_delay = 3;
        send_bytes({vecs[2].b, vecs[2].a}, 8, 0);
        repeat (100) @(negedge sys_clk);
        check("hold_no_load", 64'(n_load - l0), 64'd0);
        check("hold_tx_data", 64'(tx_data), 64'(vecs[3].c[63:48]));
        check("hold_busy", 64'(busy), 64'd1);
        @(posedge sys_clk);
        #1 ready_hold = 1'b0;
        rel = cyc;
        wait_done(n_done + 1, 300, "hold_frame_done");
        check("hold_first_load_cycle", 64'(cyc_at(base) - rel), 64'd1);
        check_words(base, vecs[2].c, "hold");

        // reset in the middle of a frame
        send_bytes({vecs[2].b, vecs[2].a}, 5, 1);
        rst = 1'b1;
        @(negedge sys_clk);
        rst = 1'b0;
        check("rst_mid_mats", {mat_b, mat_a}, 64'd0);
        check("rst_mid_ctrl", 64'({busy, load, mult_start}), 64'd0);
        @(negedge sys_clk);
        check("rst_after_ctrl", 64'({load, mult_start}), 64'd0);
        run_vec(vecs[0], "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
